// File: rtl/alu_cmd_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// alu_cmd_pkg
// Shared definitions for the ALU command sequencer:
//   - state_t     : sequencer FSM state encoding
//   - CMD_W       : width of one packed command word held in the FIFO
//   - *_OFF       : bit offsets of each field inside the packed command
//   - pack_cmd()  : builds a packed command word from its fields
// Packed layout (MSB..LSB): x[7:0], y[7:0], s[3:0], shamt[2:0], shdir, use_acc
// ----------------------------------------------------------------------------
package alu_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam int CMD_W = 25;

    localparam int USE_ACC_OFF = 0;
    localparam int SHDIR_OFF   = 1;
    localparam int SHAMT_OFF   = 2;
    localparam int S_OFF       = 5;
    localparam int Y_OFF       = 9;
    localparam int X_OFF       = 17;

    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [7:0] x,
        input logic [7:0] y,
        input logic [3:0] s,
        input logic [2:0] shamt,
        input logic       shdir,
        input logic       use_acc
    );
        return {x, y, s, shamt, shdir, use_acc};
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer_if
// Bundles the three channels of the sequencer:
//   cmd_* : command input handshake (valid/ready) and operand fields
//   alu_* : registered operands to the combinational ALU and its result back
//   res_* : result output handshake (valid/ready) with data and carry
// Modports:
//   slave  : the sequencer side
//   master : the environment side (command producer, ALU, result consumer)
// ----------------------------------------------------------------------------
interface alu_cmd_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x;
    logic [7:0] cmd_y;
    logic [3:0] cmd_s;
    logic [2:0] cmd_shamt;
    logic       cmd_shdir;
    logic       cmd_use_acc;

    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [3:0] alu_s;
    logic [2:0] alu_shamt;
    logic       alu_shdir;
    logic [7:0] alu_outp;
    logic       alu_cout;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_cout;

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_s, cmd_shamt, cmd_shdir, cmd_use_acc,
        output cmd_ready,
        output alu_x, alu_y, alu_s, alu_shamt, alu_shdir,
        input  alu_outp, alu_cout,
        output res_valid, res_data, res_cout,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_s, cmd_shamt, cmd_shdir, cmd_use_acc,
        input  cmd_ready,
        input  alu_x, alu_y, alu_s, alu_shamt, alu_shdir,
        output alu_outp, alu_cout,
        input  res_valid, res_data, res_cout,
        output res_ready
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// ----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous FIFO with registered pointers and an occupancy counter that is
// one bit wider than the pointers so full and empty are distinguishable.
// Read data is the current head (show-ahead); no write-to-read bypass.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : write request and data; ignored when full
//   pop, dout     : read request and head data; pop ignored when empty
//   full, empty   : occupancy flags
//   count         : entries held, 0..DEPTH
// ----------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only ever read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer
// Queues ALU commands, issues them one at a time to an external combinational
// ALU, captures result and carry, and offers them on a valid/ready port. An
// accumulator holding the last captured result can replace operand X.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : alu_cmd_sequencer_if.slave (cmd_*, alu_*, res_* channels)
//   busy      : FIFO non-empty or FSM not idle
//   stat_ops, stat_carries : capture / carry counters, saturating, present
//                            only when ALU_CMD_SEQUENCER_STATS_EN is defined
// ----------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_cmd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_cmd_sequencer_if.slave    bus,
    output logic                  busy
`ifdef ALU_CMD_SEQUENCER_STATS_EN
    ,
    output logic [15:0]           stat_ops,
    output logic [15:0]           stat_carries
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic [CMD_W-1:0] fifo_din;
    logic [CMD_W-1:0] head;
    logic             capture;

    logic [7:0]       alu_x_q;
    logic [7:0]       alu_y_q;
    logic [3:0]       alu_s_q;
    logic [2:0]       alu_shamt_q;
    logic             alu_shdir_q;
    logic [7:0]       res_data_q;
    logic             res_cout_q;
    logic [7:0]       acc_q;

    assign fifo_din  = pack_cmd(bus.cmd_x, bus.cmd_y, bus.cmd_s,
                                bus.cmd_shamt, bus.cmd_shdir, bus.cmd_use_acc);
    assign fifo_push = bus.cmd_valid && !fifo_full;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.cmd_ready = !fifo_full;
    assign bus.alu_x     = alu_x_q;
    assign bus.alu_y     = alu_y_q;
    assign bus.alu_s     = alu_s_q;
    assign bus.alu_shamt = alu_shamt_q;
    assign bus.alu_shdir = alu_shdir_q;
    assign bus.res_valid = (state_q == ST_RESP);
    assign bus.res_data  = res_data_q;
    assign bus.res_cout  = res_cout_q;
    assign busy          = (fifo_count != '0) || (state_q != ST_IDLE);

    // Next state. A result left unconsumed keeps the FSM in RESP; a consumed
    // result with more work queued goes straight back to ISSUE.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The accumulator is written at capture, so a chained command popped in
    // RESP already sees the result of the command issued just before it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_s_q     <= '0;
            alu_shamt_q <= '0;
            alu_shdir_q <= 1'b0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            acc_q       <= '0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) begin
                alu_x_q     <= head[USE_ACC_OFF] ? acc_q : head[X_OFF +: 8];
                alu_y_q     <= head[Y_OFF +: 8];
                alu_s_q     <= head[S_OFF +: 4];
                alu_shamt_q <= head[SHAMT_OFF +: 3];
                alu_shdir_q <= head[SHDIR_OFF];
            end
            if (capture) begin
                res_data_q <= bus.alu_outp;
                res_cout_q <= bus.alu_cout;
                acc_q      <= bus.alu_outp;
            end
        end
    end

`ifdef ALU_CMD_SEQUENCER_STATS_EN
    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops     <= '0;
            stat_carries <= '0;
        end else if (capture) begin
            if (stat_ops != 16'hFFFF) begin
                stat_ops <= stat_ops + 16'd1;
            end
            if (bus.alu_cout && (stat_carries != 16'hFFFF)) begin
                stat_carries <= stat_carries + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Directed bench for alu_cmd_sequencer with a stub adder ALU
// ({cout,outp} = X + Y for every select). Expected results are computed from
// the command stream when each command is accepted and queued; a monitor pops
// and compares them whenever a result is handed over.
// Optional counters are checked when ALU_CMD_SEQUENCER_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    logic clk;
    logic rst;
    logic busy;
`ifdef ALU_CMD_SEQUENCER_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_carries;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [8:0] exp_q [$];
    logic [8:0] mon_exp;
    logic [7:0] model_acc;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy)
`ifdef ALU_CMD_SEQUENCER_STATS_EN
        ,
        .stat_ops     (stat_ops),
        .stat_carries (stat_carries)
`endif
    );

    // Stub ALU: plain 8-bit add with carry out, select/shift ignored.
    assign {bus.alu_cout, bus.alu_outp} = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClock();
        @(posedge clk);
        #1;
    endtask

    // Drives one command and holds it until accepted (bounded). On accept the
    // expected result is derived from the model accumulator and queued.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                                 input logic [3:0] s, input logic [2:0] shamt,
                                 input logic shdir, input logic use_acc);
        logic       accepted;
        logic [8:0] sum;
        accepted        = 1'b0;
        bus.cmd_x       = x;
        bus.cmd_y       = y;
        bus.cmd_s       = s;
        bus.cmd_shamt   = shamt;
        bus.cmd_shdir   = shdir;
        bus.cmd_use_acc = use_acc;
        bus.cmd_valid   = 1'b1;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (accepted) begin
            sum       = {1'b0, (use_acc ? model_acc : x)} + {1'b0, y};
            model_acc = sum[7:0];
            exp_q.push_back(sum);
        end else begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL cmd_accept_timeout observed=cmd_ready_low expected=accept");
        end
    endtask

    task automatic waitIdle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL drain_timeout observed=busy=%0b pending=%0d expected=idle",
                   busy, exp_q.size());
        end
        waitClock();
    endtask

    // Result monitor: a handover happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL unexpected_result observed=%0h expected=none",
                       {bus.res_cout, bus.res_data});
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("result", {7'd0, bus.res_cout, bus.res_data}, {7'd0, mon_exp});
            end
        end
    end

    initial begin
        rst             = 1'b1;
        model_acc       = 8'd0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_x       = 8'd0;
        bus.cmd_y       = 8'd0;
        bus.cmd_s       = 4'd0;
        bus.cmd_shamt   = 3'd0;
        bus.cmd_shdir   = 1'b0;
        bus.cmd_use_acc = 1'b0;
        bus.res_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_cmd_ready", 16'(bus.cmd_ready), 16'd1);
        checkOutput("rst_res_valid", 16'(bus.res_valid), 16'd0);
        checkOutput("rst_busy",      16'(busy),          16'd0);
        checkOutput("rst_alu_x",     16'(bus.alu_x),     16'd0);
        checkOutput("rst_res_data",  16'(bus.res_data),  16'd0);
        checkOutput("rst_res_cout",  16'(bus.res_cout),  16'd0);

        $display("[TB] single command and latency");
        applyStimulus(8'd10, 8'd5, 4'hA, 3'd3, 1'b1, 1'b0);
        checkOutput("t1_valid_n",   16'(bus.res_valid), 16'd0);
        waitClock();
        checkOutput("t1_alu_x",     16'(bus.alu_x),     16'd10);
        checkOutput("t1_alu_y",     16'(bus.alu_y),     16'd5);
        checkOutput("t1_alu_s",     16'(bus.alu_s),     16'hA);
        checkOutput("t1_alu_shamt", 16'(bus.alu_shamt), 16'd3);
        checkOutput("t1_alu_shdir", 16'(bus.alu_shdir), 16'd1);
        checkOutput("t1_valid_n1",  16'(bus.res_valid), 16'd0);
        waitClock();
        checkOutput("t1_valid_n2",  16'(bus.res_valid), 16'd1);
        waitIdle();

        $display("[TB] carry");
        applyStimulus(8'd200, 8'd100, 4'h3, 3'd0, 1'b0, 1'b0);
        waitIdle();
`ifdef ALU_CMD_SEQUENCER_STATS_EN
        checkOutput("stat_ops",     stat_ops,     16'd2);
        checkOutput("stat_carries", stat_carries, 16'd1);
`endif

        $display("[TB] accumulator chaining");
        applyStimulus(8'd7, 8'd20, 4'h0, 3'd0, 1'b0, 1'b0);
        applyStimulus(8'd0, 8'd50, 4'h0, 3'd0, 1'b0, 1'b1);
        waitClock();
        waitClock();
        checkOutput("t3_alu_x_chain", 16'(bus.alu_x), 16'd27);
        waitIdle();

        $display("[TB] backpressure and full");
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i * 10), 8'd3, 4'h0, 3'd0, 1'b0, 1'b0);
        end
        checkOutput("t4_cmd_ready_full", 16'(bus.cmd_ready), 16'd0);
        checkOutput("t4_res_valid",      16'(bus.res_valid), 16'd1);
        checkOutput("t4_res_hold",       16'(bus.res_data),  16'd13);
        checkOutput("t4_busy",           16'(busy),          16'd1);
        waitClock();
        checkOutput("t4_res_hold2",      16'(bus.res_data),  16'd13);
        bus.res_ready = 1'b1;
        waitIdle();
        checkOutput("t4_cmd_ready_back", 16'(bus.cmd_ready), 16'd1);
        checkOutput("t4_pending",        16'(exp_q.size()),  16'd0);

        $display("[TB] reset mid-operation");
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 8'(i + 1), 4'h0, 3'd0, 1'b0, 1'b0);
        end
        bus.res_ready = 1'b1;
        waitClock();
        checkOutput("t5_issue_valid", 16'(bus.res_valid), 16'd0);
        checkOutput("t5_issue_busy",  16'(busy),          16'd1);
        rst           = 1'b1;
        bus.res_ready = 1'b0;
        exp_q.delete();
        model_acc     = 8'd0;
        waitClock();
        rst = 1'b0;
        checkOutput("t5_res_valid", 16'(bus.res_valid), 16'd0);
        checkOutput("t5_cmd_ready", 16'(bus.cmd_ready), 16'd1);
        checkOutput("t5_busy",      16'(busy),          16'd0);
        checkOutput("t5_res_data",  16'(bus.res_data),  16'd0);
        waitClock();
        checkOutput("t5_stay_idle", 16'(busy),          16'd0);
        bus.res_ready = 1'b1;
        applyStimulus(8'd123, 8'd9, 4'h0, 3'd0, 1'b0, 1'b1);
        waitClock();
        checkOutput("t5_alu_x_acc0", 16'(bus.alu_x), 16'd0);
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequences the team's 8-bit combinational ALU (operands X/Y, 4-bit select S, 3-bit shift amount, shift direction; outputs 8-bit result and carry).
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per operation to the ALU, registers the result plus carry, and presents it on a valid/ready result port.
- Keeps an accumulator so a command can chain on the previous result.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- cmd_x  in  8  X operand.
- cmd_y  in  8  Y operand.
- cmd_s  in  4  ALU select.
- cmd_shamt  in  3  shift amount.
- cmd_shdir  in  1  shift direction.
- cmd_use_acc  in  1  replace X with accumulator at issue.
- alu_x  out  8  registered ALU operand X.
- alu_y  out  8  registered ALU operand Y.
- alu_s  out  4  registered ALU select.
- alu_shamt  out  3  registered shift amount.
- alu_shdir  out  1  registered shift direction.
- alu_outp  in  8  ALU result.
- alu_cout  in  1  ALU carry.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_data  out  8  captured result.
- res_cout  out  1  captured carry.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (synchronous on rst=1 at a clk edge):
  - All outputs go to 0, FIFO is emptied, accumulator is 0, FSM goes to IDLE.
  - cmd_ready is 1 from the first cycle after reset.
  - Reset mid-operation discards the queued commands and any in-flight or unconsumed result.
- Push rule:
  - A command is pushed when cmd_valid and cmd_ready are both high at a clk edge.
  - cmd_ready = !full.
  - No bypass: a push into an empty FIFO is visible to the FSM the next cycle.
- FIFO:
  - Write and read pointers wrap modulo DEPTH.
  - Full/empty are distinguished by an extra count bit, count 0..DEPTH.
  - Simultaneous push and pop is legal when not full; count is unchanged.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if FIFO is non-empty, pop the head and load the alu_* registers (alu_x = acc when cmd_use_acc, else cmd_x); go to ISSUE.
  - ISSUE: lasts exactly one cycle so the ALU can settle. At its closing edge, capture alu_outp into res_data and acc, capture alu_cout into res_cout, set res_valid; go to RESP.
  - RESP: res_valid=1; res_data/res_cout stay stable until res_ready.
    - On res_valid&&res_ready with FIFO non-empty: pop the next command and reload alu_* in the same edge; go to ISSUE.
    - Otherwise: go to IDLE, res_valid=0.
- Outputs and timing:
  - alu_* outputs hold their last issued values while IDLE/RESP; they are not cleared.
  - Latency: a command accepted at edge N into an empty idle block has res_valid high after edge N+2.
  - Back-to-back throughput with res_ready tied 1: one result per 2 cycles.
- Accumulator chaining: acc updates only on a capture. Chained commands see the result of the immediately preceding issued command, even if that result is not yet consumed.
- Widths: operands and result are 8-bit; no internal arithmetic beyond FIFO pointers and count.

Optional Feature:
- Macro: ALU_CMD_SEQUENCER_STATS_EN.
- When defined, adds outputs stat_ops[15:0] and stat_carries[15:0]:
  - stat_ops counts captures; stat_carries counts captures with alu_cout=1.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package alu_cmd_pkg:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2).
  - Packed command width constant CMD_W=25 (x8, y8, s4, shamt3, shdir1, use_acc1).
  - Field offset constants.
- Sub-module alu_cmd_fifo: synchronous FIFO, DEPTH/width parameters, push/pop/full/empty/count.

Test Plan:
Bench connects a stub ALU with result {cout,outp} = X+Y for every S.
1. Single command: x=10, y=5, use_acc=0, res_ready=1 → alu_x=10 and alu_y=5 one cycle after push; res_data=15, res_cout=0, res_valid exactly 2 cycles after accept.
2. Carry: x=200, y=100 → res_data=44, res_cout=1.
3. Chaining: push (7,20,acc=0) then (x=0,y=50,acc=1) → results 27, then 77; second issue drives alu_x=27.
4. Backpressure and full: res_ready=0, push 5 commands → cmd_ready drops after the 4th FIFO push; res_data holds the first result. Release res_ready → all results arrive in order; cmd_ready returns.
5. Reset mid-op: rst asserted during ISSUE with 3 queued → next cycle res_valid=0, cmd_ready=1, busy=0, acc=0. A following chained command (x ignored, y=9) yields 9.
6. With ALU_CMD_SEQUENCER_STATS_EN: run scenarios 1–2 → stat_ops=2, stat_carries=1.
